// File: rtl/line_fill_arbiter.sv
// line_fill_arbiter: serialises whole-line bursts from the I-cache (refill
// reads) and the D-cache (refill reads / write-backs) onto the single shared
// memory beat port. Contention policy: D-cache always wins by default; define
// ARB_ROUND_ROBIN_EN to alternate between requesters using last_owner.
`timescale 1ns/1ps
module line_fill_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int BEATS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_rvalid,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_wnext,
  output logic              dc_rvalid,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              owner,
  output logic              busy
);

  localparam int BW    = $clog2(BEATS);
  localparam int BYTES = DATA_W / 8;
  // Clears the byte offset within a line to form the line base address.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(BEATS * BYTES - 1);

  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

  state_t            state, state_nxt;
  logic [BW-1:0]     beat;
  logic              we_r;
  logic              last_owner;
  logic [ADDR_W-1:0] base_r;
  logic              grant_any;
  logic              grant_dc;
  logic              ack;
  logic              last_beat;

  assign grant_any = ic_req | dc_req;

`ifdef ARB_ROUND_ROBIN_EN
  // On contention the requester that was not served last wins.
  assign grant_dc = dc_req & (~ic_req | ~last_owner);
`else
  // On contention the D-cache always wins; I-cache starvation is accepted.
  assign grant_dc = dc_req;
`endif

  // mem_ack only counts while a burst is actually being driven.
  assign ack       = (state == GRANT) & mem_ack;
  assign last_beat = (beat == BW'(BEATS - 1));

  // State register; reset drops straight back to IDLE without a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic: one pass IDLE -> GRANT (BEATS acks) -> DONE -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = GRANT;
      GRANT:   if (ack && last_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant bookkeeping: owner, direction, beat counter and fairness history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner      <= 1'b0;
      we_r       <= 1'b0;
      beat       <= '0;
      last_owner <= 1'b1;
    end else begin
      case (state)
        IDLE: if (grant_any) begin
          owner <= grant_dc;
          we_r  <= grant_dc & dc_we;
          beat  <= '0;
        end
        GRANT: if (ack) beat <= beat + BW'(1);
        DONE:  last_owner <= owner;
        default: ;
      endcase
    end
  end

  // Line base address; only observed in GRANT so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && grant_any)
      base_r <= (grant_dc ? dc_addr : ic_addr) & LINE_MASK;
  end

  // Output decode: every strobe is derived from state, so reset clears them at once.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ic_rvalid = 1'b0;
    dc_rvalid = 1'b0;
    dc_wnext  = 1'b0;
    ic_done   = 1'b0;
    dc_done   = 1'b0;
    busy      = (state != IDLE);
    ic_rdata  = mem_rdata;
    dc_rdata  = mem_rdata;
    if (state == GRANT) begin
      mem_req   = 1'b1;
      mem_we    = we_r;
      mem_addr  = base_r + ADDR_W'(beat) * ADDR_W'(BYTES);
      mem_wdata = dc_wdata;
      ic_rvalid = ack & ~owner & ~we_r;
      dc_rvalid = ack &  owner & ~we_r;
      dc_wnext  = ack & we_r;
    end
    if (state == DONE) begin
      ic_done = ~owner;
      dc_done = owner;
    end
  end

endmodule

// File: tb/tb_line_fill_arbiter.sv
// tb_line_fill_arbiter: directed vector table for single-requester bursts,
// plus hand-written sequences for wait states, contention, mid-burst reset
// and back-to-back requests.
`timescale 1ns/1ps
module tb_line_fill_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_req, dc_req, dc_we, mem_ack;
  logic [63:0] ic_addr, dc_addr, dc_wdata, mem_rdata;
  logic        ic_rvalid, ic_done, dc_wnext, dc_rvalid, dc_done;
  logic        mem_req, mem_we, owner, busy;
  logic [63:0] ic_rdata, dc_rdata, mem_addr, mem_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  line_fill_arbiter #(.ADDR_W(64), .DATA_W(64), .BEATS(4)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rvalid(ic_rvalid),
    .ic_rdata(ic_rdata), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_wnext(dc_wnext), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
    .dc_done(dc_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .owner(owner), .busy(busy)
  );

  typedef struct {
    logic        ic_req;
    logic [63:0] ic_addr;
    logic        dc_req;
    logic        dc_we;
    logic [63:0] dc_addr;
    logic        ack;
    logic [63:0] rdata;
    logic        e_req;
    logic        e_we;
    logic [63:0] e_addr;
    logic        e_irv;
    logic        e_drv;
    logic        e_idone;
    logic        e_ddone;
    logic        e_owner;
    logic        e_busy;
  } vec_t;

  vec_t        tbl[15];
  logic [63:0] wv[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One complete zero-wait burst starting from an IDLE cycle with requests held.
  task automatic run_burst(input logic exp_owner, input logic [63:0] base);
    mem_ack = 1'b0;
    #1;
    chk("burst_idle_req", {63'd0, mem_req}, 64'd0);
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      mem_ack   = 1'b1;
      mem_rdata = 64'hC0DE_0000_0000_0000 | 64'(b);
      #1;
      chk("burst_req",   {63'd0, mem_req}, 64'd1);
      chk("burst_owner", {63'd0, owner}, {63'd0, exp_owner});
      chk("burst_addr",  mem_addr, base + 64'(b * 8));
      chk("burst_rvalid", {62'd0, dc_rvalid, ic_rvalid}, exp_owner ? 64'd2 : 64'd1);
      @(negedge clk);
    end
    mem_ack = 1'b0;
    #1;
    chk("burst_done", {62'd0, dc_done, ic_done}, exp_owner ? 64'd2 : 64'd1);
    chk("burst_done_req", {63'd0, mem_req}, 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Lone I-cache refill at 0x1234 (line 0x1220), then idle ack, then a
    // D-cache read of 0x2F (line 0x20) with one wait state on beat 0.
    tbl[0]  = '{1'b1, 64'h1234, 1'b0, 1'b0, 64'h0,  1'b0, 64'h0,  1'b0, 1'b0, 64'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 64'h1234, 1'b0, 1'b0, 64'h0,  1'b1, 64'hA1, 1'b1, 1'b0, 64'h1220, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 64'h1234, 1'b0, 1'b0, 64'h0,  1'b1, 64'hA2, 1'b1, 1'b0, 64'h1228, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 64'h1234, 1'b0, 1'b0, 64'h0,  1'b1, 64'hA3, 1'b1, 1'b0, 64'h1230, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 64'h1234, 1'b0, 1'b0, 64'h0,  1'b1, 64'hA4, 1'b1, 1'b0, 64'h1238, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 64'h1234, 1'b0, 1'b0, 64'h0,  1'b0, 64'h0,  1'b0, 1'b0, 64'h0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 64'h0,    1'b0, 1'b0, 64'h0,  1'b1, 64'hFF, 1'b0, 1'b0, 64'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 64'h0,    1'b1, 1'b0, 64'h2F, 1'b0, 64'h0,  1'b0, 1'b0, 64'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 64'h0,    1'b1, 1'b0, 64'h2F, 1'b0, 64'h0,  1'b1, 1'b0, 64'h20,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 64'h0,    1'b1, 1'b0, 64'h2F, 1'b1, 64'hB1, 1'b1, 1'b0, 64'h20,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 64'h0,    1'b1, 1'b0, 64'h2F, 1'b1, 64'hB2, 1'b1, 1'b0, 64'h28,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 64'h0,    1'b1, 1'b0, 64'h2F, 1'b1, 64'hB3, 1'b1, 1'b0, 64'h30,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 64'h0,    1'b1, 1'b0, 64'h2F, 1'b1, 64'hB4, 1'b1, 1'b0, 64'h38,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 64'h0,    1'b1, 1'b0, 64'h2F, 1'b0, 64'h0,  1'b0, 1'b0, 64'h0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 64'h0,    1'b0, 1'b0, 64'h0,  1'b1, 64'hEE, 1'b0, 1'b0, 64'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    wv[0] = 64'h1111_0000_0000_0001;
    wv[1] = 64'h2222_0000_0000_0002;
    wv[2] = 64'h3333_0000_0000_0003;
    wv[3] = 64'h4444_0000_0000_0004;

    rst = 1'b0;
    ic_req = 1'b0; ic_addr = '0; dc_req = 1'b0; dc_we = 1'b0;
    dc_addr = '0; dc_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_busy",    {63'd0, busy}, 64'd0);
    chk("rst_owner",   {63'd0, owner}, 64'd0);
    chk("rst_addr",    mem_addr, 64'd0);
    chk("rst_wdata",   mem_wdata, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Vector table
    for (int i = 0; i < 15; i++) begin
      ic_req    = tbl[i].ic_req;
      ic_addr   = tbl[i].ic_addr;
      dc_req    = tbl[i].dc_req;
      dc_we     = tbl[i].dc_we;
      dc_addr   = tbl[i].dc_addr;
      mem_ack   = tbl[i].ack;
      mem_rdata = tbl[i].rdata;
      #1;
      chk($sformatf("v%0d_mem_req", i),   {63'd0, mem_req},   {63'd0, tbl[i].e_req});
      chk($sformatf("v%0d_mem_we", i),    {63'd0, mem_we},    {63'd0, tbl[i].e_we});
      chk($sformatf("v%0d_mem_addr", i),  mem_addr,           tbl[i].e_addr);
      chk($sformatf("v%0d_ic_rvalid", i), {63'd0, ic_rvalid}, {63'd0, tbl[i].e_irv});
      chk($sformatf("v%0d_dc_rvalid", i), {63'd0, dc_rvalid}, {63'd0, tbl[i].e_drv});
      chk($sformatf("v%0d_dc_wnext", i),  {63'd0, dc_wnext},  64'd0);
      chk($sformatf("v%0d_ic_done", i),   {63'd0, ic_done},   {63'd0, tbl[i].e_idone});
      chk($sformatf("v%0d_dc_done", i),   {63'd0, dc_done},   {63'd0, tbl[i].e_ddone});
      chk($sformatf("v%0d_owner", i),     {63'd0, owner},     {63'd0, tbl[i].e_owner});
      chk($sformatf("v%0d_busy", i),      {63'd0, busy},      {63'd0, tbl[i].e_busy});
      if (tbl[i].e_irv) chk($sformatf("v%0d_ic_rdata", i), ic_rdata, tbl[i].rdata);
      if (tbl[i].e_drv) chk($sformatf("v%0d_dc_rdata", i), dc_rdata, tbl[i].rdata);
      @(negedge clk);
    end

    // D-cache write-back at 0x9000 with two wait states per beat
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 64'h9000; dc_wdata = wv[0];
    ic_req = 1'b0; mem_ack = 1'b0;
    #1;
    chk("wb_idle_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w < 3; w++) begin
        mem_ack = (w == 2);
        #1;
        chk("wb_req",   {62'd0, mem_req, mem_we}, 64'd3);
        chk("wb_addr",  mem_addr, 64'h9000 + 64'(b * 8));
        chk("wb_wdata", mem_wdata, wv[b]);
        chk("wb_wnext", {63'd0, dc_wnext}, (w == 2) ? 64'd1 : 64'd0);
        chk("wb_rvalid", {62'd0, dc_rvalid, ic_rvalid}, 64'd0);
        @(negedge clk);
        if (w == 2 && b < 3) dc_wdata = wv[b + 1];
      end
    end
    mem_ack = 1'b0;
    #1;
    chk("wb_done", {62'd0, dc_done, ic_done}, 64'd2);
    @(negedge clk);
    dc_req = 1'b0; dc_we = 1'b0;
    #1;
    chk("wb_after_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);

    // Contention from reset, both requests held continuously
    rst = 1'b0;
    #1;
    chk("rst2_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    ic_req = 1'b1; ic_addr = 64'h100;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 64'h208;
`ifdef ARB_ROUND_ROBIN_EN
    run_burst(1'b0, 64'h100);
    run_burst(1'b1, 64'h200);
    run_burst(1'b0, 64'h100);
`else
    run_burst(1'b1, 64'h200);
    run_burst(1'b1, 64'h200);
    run_burst(1'b1, 64'h200);
`endif
    ic_req = 1'b0; dc_req = 1'b0;
    @(negedge clk);

    // Reset asserted mid-way through beat 2 of a D-cache read
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 64'h400;
    #1;
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      mem_ack = 1'b1; mem_rdata = 64'h77;
      #1;
      @(negedge clk);
    end
    mem_ack = 1'b1; mem_rdata = 64'h55;
    #1;
    chk("mid_beat2_addr",   mem_addr, 64'h410);
    chk("mid_beat2_rvalid", {63'd0, dc_rvalid}, 64'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_req",    {63'd0, mem_req}, 64'd0);
    chk("mid_rst_rvalid", {63'd0, dc_rvalid}, 64'd0);
    chk("mid_rst_busy",   {63'd0, busy}, 64'd0);
    chk("mid_rst_addr",   mem_addr, 64'd0);
    dc_req = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_busy", {63'd0, busy}, 64'd0);

    // Fresh I-cache request, held one cycle past done: two full bursts
    ic_req = 1'b1; ic_addr = 64'h1008;
    run_burst(1'b0, 64'h1000);
    run_burst(1'b0, 64'h1000);
    ic_req = 1'b0;
    mem_ack = 1'b1; mem_rdata = 64'hDEAD;
    #1;
    chk("idle_ack_rvalid", {62'd0, dc_rvalid, ic_rvalid}, 64'd0);
    chk("idle_ack_req",    {63'd0, mem_req}, 64'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("final_busy", {63'd0, busy}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
